// File: rtl/branch_resolver.sv
// branch_resolver
//   Registered branch/jump resolution stage. Decodes the ALU SUB flag and the
//   operand sign bits into a taken/not-taken decision, computes the redirect
//   target and the link value, and holds the result in a one-entry
//   valid/ready pipeline register. Keeps wrap-around statistics counters.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready is 0 while flush=1)
//   funct3              branch condition; is_jal / is_jalr override it
//   pc, imm, rs1        PC, sign-extended offset, JALR base
//   alu_c               ALU rs1-rs2 result (debug only, not used for decode)
//   alu_f               ALU flag: 00 zero, 01 negative, 10 positive, 11 invalid
//   a_msb, b_msb        bit 31 of rs1 / rs2
//   flush               drop the held entry and any same-cycle request
//   out_valid/out_ready result handshake
//   taken, target, link, misalign, illegal   resolved result
//   br_cnt, taken_cnt   legal conditional branches / taken redirects accepted
module branch_resolver #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  alu_c,
  input  logic [1:0]       alu_f,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [XLEN-1:0]  target,
  output logic [XLEN-1:0]  link,
  output logic             misalign,
  output logic             illegal,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              taken_q, misalign_q, illegal_q;
  logic [XLEN-1:0]   target_q, link_q;
  logic [CNT_W-1:0]  br_cnt_q, taken_cnt_q;

  logic              accept;
  logic              is_cond;
  logic              eq, neg, lt, ltu;
  logic              cond_hit, f3_bad;
  logic              taken_d, illegal_d, misalign_d;
  logic [XLEN-1:0]   sum_pc, sum_rs, target_d, link_d;

  // alu_c is carried for debug visibility only
  logic              unused_alu_c;
  assign unused_alu_c = ^alu_c;

  // ---- input stage: handshake and condition decode ----
  assign in_ready = (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  assign is_cond = !is_jal && !is_jalr;
  assign eq      = (alu_f == 2'b00);
  assign neg     = (alu_f == 2'b01);
  // When the signs differ the SUB result can overflow, so the sign bits decide.
  assign lt      = (a_msb != b_msb) ? a_msb : neg;
  assign ltu     = (a_msb != b_msb) ? b_msb : neg;

  always_comb begin
    cond_hit = 1'b0;
    f3_bad   = 1'b0;
    case (funct3)
      3'b000:  cond_hit = eq;
      3'b001:  cond_hit = !eq;
      3'b100:  cond_hit = lt;
      3'b101:  cond_hit = !lt;
      3'b110:  cond_hit = ltu;
      3'b111:  cond_hit = !ltu;
      default: f3_bad   = 1'b1;
    endcase
  end

  assign illegal_d  = is_cond && (f3_bad || (alu_f == 2'b11));
  assign taken_d    = is_jal || is_jalr || (is_cond && !illegal_d && cond_hit);
  assign sum_pc     = pc + imm;
  assign sum_rs     = rs1 + imm;
  assign target_d   = is_jalr ? {sum_rs[XLEN-1:1], 1'b0} : sum_pc;
  assign link_d     = pc + XLEN'(4);
  assign misalign_d = taken_d && target_d[1];

  // ---- output stage: FSM state register ----
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush)
      state_d = EMPTY;
    else if (accept)
      state_d = FULL;
    else if ((state_q == FULL) && out_ready)
      state_d = EMPTY;
  end

  always_comb begin
    out_valid = (state_q == FULL);
    taken     = taken_q && out_valid;
    misalign  = misalign_q && out_valid;
    illegal   = illegal_q && out_valid;
    target    = target_q;
    link      = link_q;
    br_cnt    = br_cnt_q;
    taken_cnt = taken_cnt_q;
  end

  // ---- output stage: result register and statistics ----
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_q     <= 1'b0;
      misalign_q  <= 1'b0;
      illegal_q   <= 1'b0;
      target_q    <= '0;
      link_q      <= '0;
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else if (accept) begin
      taken_q    <= taken_d;
      misalign_q <= misalign_d;
      illegal_q  <= illegal_d;
      target_q   <= target_d;
      link_q     <= link_d;
      if (is_cond && !illegal_d) br_cnt_q    <= br_cnt_q + CNT_W'(1);
      if (taken_d)               taken_cnt_q <= taken_cnt_q + CNT_W'(1);
    end
  end

endmodule
